count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 94 +++++++++
 tb/tb_count_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Watches a free-running mod-8 counter, counts legal 7->0 wraps
// and latches a sticky fault on the first illegal step.
`timescale 1ns/1ps
module count_monitor #(
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cnt_in,
    input  logic              clr,
    output logic [2:0]        cnt_q,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              ovf,
    output logic              step_err,
    output logic              fault,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t            cur_st;
    state_t            nxt_st;
    logic [WRAP_W-1:0] wrap_cnt_n;
    logic              ovf_n;
    logic              fault_n;
    logic              wrap_pulse_n;
    logic              step_err_n;
    logic              legal;
    logic              is_wrap;

    assign legal   = (cnt_in == cnt_q + 3'd1);
    assign is_wrap = legal && (cnt_q == 3'd7);
    assign state   = cur_st;

    always_comb begin
        nxt_st       = cur_st;
        wrap_cnt_n   = wrap_cnt;
        ovf_n        = ovf;
        fault_n      = fault;
        wrap_pulse_n = 1'b0;
        step_err_n   = 1'b0;
        if (clr) begin
            nxt_st     = INIT;
            wrap_cnt_n = '0;
            ovf_n      = 1'b0;
            fault_n    = 1'b0;
        end else begin
            unique case (cur_st)
                INIT: nxt_st = TRACK;
                TRACK: begin
                    if (!legal) begin
                        step_err_n = 1'b1;
                        fault_n    = 1'b1;
                        nxt_st     = FAULT;
                    end else if (is_wrap) begin
                        wrap_pulse_n = 1'b1;
                        wrap_cnt_n   = wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
                        if (&wrap_cnt)
                            ovf_n = 1'b1;
                    end
                end
                FAULT: nxt_st = FAULT;
                default: nxt_st = INIT;
            endcase
        end
    end

    // cnt_q tracks cnt_in every edge regardless of state or clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st     <= INIT;
            cnt_q      <= 3'd0;
            wrap_cnt   <= '0;
            ovf        <= 1'b0;
            fault      <= 1'b0;
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            cnt_q      <= cnt_in;
            wrap_cnt   <= wrap_cnt_n;
            ovf        <= ovf_n;
            fault      <= fault_n;
            wrap_pulse <= wrap_pulse_n;
            step_err   <= step_err_n;
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: wraps, overflow, illegal
// steps, clr priority and asynchronous reset.
`timescale 1ns/1ps
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] cnt_in = 3'd0;
    logic       clr = 1'b0;
    logic [2:0] cnt_q;
    logic       wrap_pulse;
    logic [3:0] wrap_cnt;
    logic       ovf;
    logic       step_err;
    logic       fault;
    logic [1:0] state;

    int total = 0;
    int passed = 0;

    count_monitor #(.WRAP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .cnt_q      (cnt_q),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .ovf        (ovf),
        .step_err   (step_err),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    // drive on the falling edge, observe 1ns after the rising edge
    task automatic step(input logic [2:0] v);
        @(negedge clk);
        cnt_in = v;
        @(posedge clk);
        #1;
    endtask

    // pulse reset, then let the INIT edge capture v; ends in TRACK
    task automatic do_reset(input logic [2:0] v);
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        cnt_in = v;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_wraps(input int n);
        for (int w = 0; w < n; w++)
            for (int k = 1; k <= 8; k++)
                step(3'(k));
    endtask

    task automatic test_reset();
        cnt_in = 3'd5;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (state !== 2'b00) $display("FAIL rst_state got %b want 00", state);
        else passed++;
        total++;
        if (cnt_q !== 3'd0) $display("FAIL rst_cnt_q got %0d want 0", cnt_q);
        else passed++;
        total++;
        if ({wrap_cnt, ovf, fault, wrap_pulse, step_err} !== 8'h00)
            $display("FAIL rst_outs got %h/%b%b%b%b want 0",
                     wrap_cnt, ovf, fault, wrap_pulse, step_err);
        else passed++;
    endtask

    task automatic test_first_wrap();
        logic any_err;
        logic any_pulse;
        do_reset(3'd0);
        total++;
        if (state !== 2'b01 || cnt_q !== 3'd0)
            $display("FAIL init_edge got st=%b q=%0d want 01/0", state, cnt_q);
        else passed++;
        any_err = 1'b0;
        any_pulse = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(3'(k));
            any_err |= step_err;
            any_pulse |= wrap_pulse;
        end
        total++;
        if (any_err !== 1'b0 || any_pulse !== 1'b0)
            $display("FAIL run_quiet got err=%b pulse=%b want 0/0", any_err, any_pulse);
        else passed++;
        step(3'd0);
        total++;
        if (wrap_pulse !== 1'b1 || wrap_cnt !== 4'd1 || step_err !== 1'b0)
            $display("FAIL first_wrap got p=%b c=%0d e=%b want 1/1/0",
                     wrap_pulse, wrap_cnt, step_err);
        else passed++;
        step(3'd1);
        total++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== 4'd1 || step_err !== 1'b0)
            $display("FAIL wrap_one_cycle got p=%b c=%0d e=%b want 0/1/0",
                     wrap_pulse, wrap_cnt, step_err);
        else passed++;
    endtask

    task automatic test_overflow();
        do_reset(3'd0);
        run_wraps(15);
        total++;
        if (wrap_cnt !== 4'd15 || ovf !== 1'b0)
            $display("FAIL pre_ovf got c=%0d ovf=%b want 15/0", wrap_cnt, ovf);
        else passed++;
        run_wraps(1);
        total++;
        if (wrap_cnt !== 4'd0 || ovf !== 1'b1 || fault !== 1'b0)
            $display("FAIL ovf got c=%0d ovf=%b f=%b want 0/1/0", wrap_cnt, ovf, fault);
        else passed++;
        run_wraps(1);
        total++;
        if (wrap_cnt !== 4'd1 || ovf !== 1'b1)
            $display("FAIL ovf_sticky got c=%0d ovf=%b want 1/1", wrap_cnt, ovf);
        else passed++;
    endtask

    task automatic test_skip();
        do_reset(3'd6);
        step(3'd7);
        step(3'd0);
        step(3'd1);
        step(3'd2);
        step(3'd3);
        step(3'd5);
        total++;
        if (step_err !== 1'b1 || fault !== 1'b1 || state !== 2'b10 || wrap_cnt !== 4'd1)
            $display("FAIL skip got e=%b f=%b st=%b c=%0d want 1/1/10/1",
                     step_err, fault, state, wrap_cnt);
        else passed++;
        step(3'd6);
        total++;
        if (step_err !== 1'b0 || fault !== 1'b1 || state !== 2'b10)
            $display("FAIL skip_after got e=%b f=%b st=%b want 0/1/10",
                     step_err, fault, state);
        else passed++;
        step(3'd7);
        step(3'd0);
        total++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== 4'd1 || cnt_q !== 3'd0)
            $display("FAIL fault_frozen got p=%b c=%0d q=%0d want 0/1/0",
                     wrap_pulse, wrap_cnt, cnt_q);
        else passed++;
    endtask

    task automatic test_hold();
        do_reset(3'd3);
        step(3'd4);
        step(3'd4);
        total++;
        if (step_err !== 1'b1 || fault !== 1'b1 || state !== 2'b10 || wrap_cnt !== 4'd0)
            $display("FAIL hold got e=%b f=%b st=%b c=%0d want 1/1/10/0",
                     step_err, fault, state, wrap_cnt);
        else passed++;
        @(negedge clk);
        clr = 1'b1;
        cnt_in = 3'd2;
        @(posedge clk);
        #1;
        clr = 1'b0;
        total++;
        if (state !== 2'b00 || fault !== 1'b0 || step_err !== 1'b0 || cnt_q !== 3'd2)
            $display("FAIL clr_fault got st=%b f=%b e=%b q=%0d want 00/0/0/2",
                     state, fault, step_err, cnt_q);
        else passed++;
        step(3'd6);
        total++;
        if (state !== 2'b01 || step_err !== 1'b0)
            $display("FAIL clr_reinit got st=%b e=%b want 01/0", state, step_err);
        else passed++;
    endtask

    task automatic test_clr_wrap();
        do_reset(3'd0);
        run_wraps(5);
        for (int k = 1; k <= 7; k++)
            step(3'(k));
        total++;
        if (wrap_cnt !== 4'd5)
            $display("FAIL clr_setup got c=%0d want 5", wrap_cnt);
        else passed++;
        @(negedge clk);
        clr = 1'b1;
        cnt_in = 3'd0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        total++;
        if (wrap_cnt !== 4'd0 || wrap_pulse !== 1'b0 || state !== 2'b00 || cnt_q !== 3'd0)
            $display("FAIL clr_wins got c=%0d p=%b st=%b q=%0d want 0/0/00/0",
                     wrap_cnt, wrap_pulse, state, cnt_q);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset(3'd0);
        run_wraps(16);
        step(3'd2);
        total++;
        if (ovf !== 1'b1 || state !== 2'b10 || step_err !== 1'b1)
            $display("FAIL async_setup got ovf=%b st=%b e=%b want 1/10/1",
                     ovf, state, step_err);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({state, cnt_q, wrap_cnt, ovf, fault, wrap_pulse, step_err} !== 13'd0)
            $display("FAIL async_rst got st=%b q=%0d c=%0d ovf=%b f=%b p=%b e=%b want all 0",
                     state, cnt_q, wrap_cnt, ovf, fault, wrap_pulse, step_err);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_wrap();
        test_overflow();
        test_skip();
        test_hold();
        test_clr_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
